// File: rtl/bram_snapshot_writer.sv
// Arm/trigger snapshot capture of a sample stream into consecutive BRAM words.
// Optional SNAP_DECIM_EN adds a decim port: keep 1 of every (decim+1) valid samples.
module bram_snapshot_writer #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int DECIM_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic                  arm,
    input  logic                  trigger,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   capture_len,
`ifdef SNAP_DECIM_EN
    input  logic [DECIM_WIDTH-1:0] decim,
`endif
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  bram_we,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   words_written,
    output logic [1:0]            fsm_state
);

    // Handshake: din is consumed on any cycle din_valid=1; there is no back-pressure.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                 state;
    logic [ADDR_WIDTH:0]    len_l;
    logic [ADDR_WIDTH:0]    eff_len;
    logic [ADDR_WIDTH:0]    ww_next;
    logic [DECIM_WIDTH-1:0] decim_in;
    logic [DECIM_WIDTH-1:0] decim_l;
    logic [DECIM_WIDTH-1:0] dcnt;
    logic                   take;

`ifdef SNAP_DECIM_EN
    assign decim_in = decim;
`else
    assign decim_in = '0;
`endif

    assign fsm_state = state;
    assign ww_next   = words_written + (ADDR_WIDTH+1)'(1);

    always_comb begin
        eff_len = capture_len;
        if (capture_len == '0 || capture_len > DEPTH) eff_len = DEPTH;
    end

    // Abort suppresses the write issued in the same cycle.
    always_comb begin
        take = 1'b0;
        if (!abort && din_valid) begin
            if (state == ARMED && trigger) take = 1'b1;
            else if (state == CAPTURE && dcnt == '0) take = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bram_addr     <= '0;
            bram_din      <= '0;
            bram_we       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            words_written <= '0;
            len_l         <= '0;
            decim_l       <= '0;
            dcnt          <= '0;
        end else begin
            bram_we <= take;
            if (take) begin
                bram_din      <= din;
                bram_addr     <= words_written[ADDR_WIDTH-1:0];
                words_written <= ww_next;
            end
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (arm) begin
                            state         <= ARMED;
                            busy          <= 1'b1;
                            done          <= 1'b0;
                            words_written <= '0;
                            len_l         <= eff_len;
                            decim_l       <= decim_in;
                        end
                    end
                    ARMED: begin
                        if (trigger) begin
                            dcnt <= (din_valid && decim_l != '0) ? DECIM_WIDTH'(1) : '0;
                            if (take && ww_next == len_l) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= CAPTURE;
                            end
                        end
                    end
                    CAPTURE: begin
                        if (din_valid) dcnt <= (dcnt == decim_l) ? '0 : dcnt + DECIM_WIDTH'(1);
                        // Last address written: stop here, pointer never wraps.
                        if (take && ww_next == len_l) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
